// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - opcodes, control word and decode table for pipe_ctrl
package pipe_pkg;

  localparam int OPC_W = 8;
  typedef logic [OPC_W-1:0] opc_t;

  localparam opc_t OP_JUMP  = 8'd1;
  localparam opc_t OP_BEQ   = 8'd2;
  localparam opc_t OP_BGT   = 8'd3;
  localparam opc_t OP_BLE   = 8'd4;
  localparam opc_t OP_LOAD  = 8'd5;
  localparam opc_t OP_STORE = 8'd6;
  localparam opc_t OP_ADD   = 8'd8;

  localparam logic [2:0] ALU_NOP = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;

  // branch field is {gt, le, eq}
  localparam logic [2:0] BR_EQ = 3'b001;
  localparam logic [2:0] BR_LE = 3'b010;
  localparam logic [2:0] BR_GT = 3'b100;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       se_op;
    logic [2:0] branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
  } ctrl_t;

  function automatic ctrl_t decode(input opc_t op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_JUMP:  c.jump = 1'b1;
      OP_BEQ:   begin c.alu_op = ALU_SUB; c.se_op = 1'b1; c.branch = BR_EQ; end
      OP_BGT:   begin c.alu_op = ALU_SUB; c.se_op = 1'b1; c.branch = BR_GT; end
      OP_BLE:   begin c.alu_op = ALU_SUB; c.se_op = 1'b1; c.branch = BR_LE; end
      OP_LOAD:  begin
        c.alu_op = ALU_ADD; c.se_op = 1'b1; c.mem_read = 1'b1;
        c.reg_write = 1'b1; c.mem_to_reg = WB_MEM;
      end
      OP_STORE: begin c.alu_op = ALU_ADD; c.se_op = 1'b1; c.mem_write = 1'b1; end
      OP_ADD:   begin c.alu_op = ALU_ADD; c.reg_write = 1'b1; c.mem_to_reg = WB_ALU; end
      default:  ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - ID-stage inputs and stage control outputs of pipe_ctrl
interface pipe_ctrl_if #(
  parameter int OPW = 4,
  parameter int RAW = 3
);
  logic           id_valid;
  logic [OPW-1:0] id_opcode;
  logic [RAW-1:0] id_rs;
  logic [RAW-1:0] id_rt;
  logic [RAW-1:0] id_rd;
  logic           ex_branch_taken;
  logic [2:0]     ex_alu_op;
  logic           ex_se_op;
  logic [2:0]     ex_branch;
  logic           mem_read;
  logic           mem_write;
  logic           wb_reg_write;
  logic [1:0]     wb_mem_to_reg;
  logic [RAW-1:0] wb_rd;
  logic           stall;
  logic           flush;
  logic [1:0]     fwd_a;
  logic [1:0]     fwd_b;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_rd, ex_branch_taken,
    input  ex_alu_op, ex_se_op, ex_branch, mem_read, mem_write,
           wb_reg_write, wb_mem_to_reg, wb_rd, stall, flush, fwd_a, fwd_b
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_rd, ex_branch_taken,
    output ex_alu_op, ex_se_op, ex_branch, mem_read, mem_write,
           wb_reg_write, wb_mem_to_reg, wb_rd, stall, flush, fwd_a, fwd_b
  );
endinterface

// File: rtl/pipe_ctrl_fwd_unit.sv
// rtl/pipe_ctrl_fwd_unit.sv - operand forwarding select for one EX source register
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int RAW = 3
) (
  input  logic [RAW-1:0] src,
  input  logic           exmem_we,
  input  logic [RAW-1:0] exmem_rd,
  input  logic           memwb_we,
  input  logic [RAW-1:0] memwb_rd,
  output logic [1:0]     sel
);
  // the younger EX/MEM result wins; register 0 is never forwarded
  always_comb begin
    sel = FWD_RF;
    if (exmem_we && (exmem_rd != '0) && (exmem_rd == src)) begin
      sel = FWD_EXMEM;
    end else if (memwb_we && (memwb_rd != '0) && (memwb_rd == src)) begin
      sel = FWD_MEMWB;
    end
  end
endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - decode, ID/EX/MEM/WB control registers, load-use stall, flush, forwarding
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int OPW = 4,
  parameter int RAW = 3
) (
  input logic       clk,
  input logic       rst_n,
  pipe_ctrl_if.slave bus
);
  typedef struct packed {
    ctrl_t          c;
    logic [RAW-1:0] rs;
    logic [RAW-1:0] rt;
    logic [RAW-1:0] rd;
  } stage_t;

  logic [OPW-1:0] id_op;
  ctrl_t          id_ctrl;
  logic           hazard;
  logic           flush_c;
  logic           stall_c;
  stage_t         idex_d, idex_q;
  stage_t         exmem_d, exmem_q;
  stage_t         memwb_d, memwb_q;

  assign id_op = bus.id_opcode;

  always_comb begin
    id_ctrl = decode(opc_t'(id_op));
    hazard  = bus.id_valid && idex_q.c.mem_read && (idex_q.rd != '0) &&
              ((idex_q.rd == bus.id_rs) || (idex_q.rd == bus.id_rt));
    // flush reads 0 while held in reset even if the inputs request one
    flush_c = rst_n && ((bus.id_valid && id_ctrl.jump) || bus.ex_branch_taken);
    stall_c = hazard && !flush_c;

    idex_d.c  = id_ctrl;
    idex_d.rs = bus.id_rs;
    idex_d.rt = bus.id_rt;
    idex_d.rd = bus.id_rd;
    if (!bus.id_valid || stall_c || bus.ex_branch_taken) begin
      idex_d = '0;
    end
    exmem_d = idex_q;
    memwb_d = exmem_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign bus.ex_alu_op     = idex_q.c.alu_op;
  assign bus.ex_se_op      = idex_q.c.se_op;
  assign bus.ex_branch     = idex_q.c.branch;
  assign bus.mem_read      = exmem_q.c.mem_read;
  assign bus.mem_write     = exmem_q.c.mem_write;
  assign bus.wb_reg_write  = memwb_q.c.reg_write;
  assign bus.wb_mem_to_reg = memwb_q.c.mem_to_reg;
  assign bus.wb_rd         = memwb_q.rd;
  assign bus.stall         = stall_c;
  assign bus.flush         = flush_c;

  fwd_unit #(.RAW(RAW)) u_fwd_a (
    .src      (idex_q.rs),
    .exmem_we (exmem_q.c.reg_write),
    .exmem_rd (exmem_q.rd),
    .memwb_we (memwb_q.c.reg_write),
    .memwb_rd (memwb_q.rd),
    .sel      (bus.fwd_a)
  );

  fwd_unit #(.RAW(RAW)) u_fwd_b (
    .src      (idex_q.rt),
    .exmem_we (exmem_q.c.reg_write),
    .exmem_rd (exmem_q.rd),
    .memwb_we (memwb_q.c.reg_write),
    .memwb_rd (memwb_q.rd),
    .sel      (bus.fwd_b)
  );

  // later stages carry the whole word; only some fields are consumed there
  logic unused_stage_bits;
  assign unused_stage_bits = ^{idex_q.c.jump, exmem_q, memwb_q};
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed and random instruction streams against an instruction-level model
module tb_pipe_ctrl;
  localparam int OPW = 4;
  localparam int RAW = 3;
  localparam int OP_JUMP = 1, OP_BEQ = 2, OP_BGT = 3, OP_BLE = 4;
  localparam int OP_LOAD = 5, OP_STORE = 6, OP_ADD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.OPW(OPW), .RAW(RAW)) bus ();
  pipe_ctrl #(.OPW(OPW), .RAW(RAW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { int op; int rs; int rt; int rd; } ins_t;
  ins_t ex_i, mem_i, wb_i;

  int checks = 0;
  int errors = 0;
  int cur_v, cur_op, cur_rs, cur_rt, cur_rd, cur_bt;
  bit m_stall, m_flush;

  function automatic int alu_of(int op);
    if (op == OP_LOAD || op == OP_STORE || op == OP_ADD) return 1;
    if (op == OP_BEQ || op == OP_BGT || op == OP_BLE) return 2;
    return 0;
  endfunction

  function automatic int se_of(int op);
    return (op == OP_LOAD || op == OP_STORE || op == OP_BEQ || op == OP_BGT || op == OP_BLE) ? 1 : 0;
  endfunction

  function automatic int br_of(int op);
    if (op == OP_BEQ) return 1;
    if (op == OP_BLE) return 2;
    if (op == OP_BGT) return 4;
    return 0;
  endfunction

  function automatic int writes(int op);
    return (op == OP_LOAD || op == OP_ADD) ? 1 : 0;
  endfunction

  function automatic int fwd_of(int src);
    if (writes(mem_i.op) != 0 && mem_i.rd != 0 && mem_i.rd == src) return 2;
    if (writes(wb_i.op) != 0 && wb_i.rd != 0 && wb_i.rd == src) return 1;
    return 0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    ex_i = '{0, 0, 0, 0};
    mem_i = '{0, 0, 0, 0};
    wb_i = '{0, 0, 0, 0};
  endtask

  task automatic drive(int v, int op, int rs, int rt, int rd, int bt);
    cur_v = v; cur_op = op; cur_rs = rs; cur_rt = rt; cur_rd = rd; cur_bt = bt;
    bus.id_valid = v[0];
    bus.id_opcode = op[OPW-1:0];
    bus.id_rs = rs[RAW-1:0];
    bus.id_rt = rt[RAW-1:0];
    bus.id_rd = rd[RAW-1:0];
    bus.ex_branch_taken = bt[0];
  endtask

  task automatic check_all();
    bit hz;
    hz = cur_v != 0 && ex_i.op == OP_LOAD && ex_i.rd != 0 &&
         (ex_i.rd == cur_rs || ex_i.rd == cur_rt);
    m_flush = rst_n && ((cur_v != 0 && cur_op == OP_JUMP) || cur_bt != 0);
    m_stall = hz && !m_flush;
    chk("ex_alu_op", 32'(bus.ex_alu_op), alu_of(ex_i.op));
    chk("ex_se_op", 32'(bus.ex_se_op), se_of(ex_i.op));
    chk("ex_branch", 32'(bus.ex_branch), br_of(ex_i.op));
    chk("mem_read", 32'(bus.mem_read), (mem_i.op == OP_LOAD) ? 1 : 0);
    chk("mem_write", 32'(bus.mem_write), (mem_i.op == OP_STORE) ? 1 : 0);
    chk("wb_reg_write", 32'(bus.wb_reg_write), writes(wb_i.op));
    chk("wb_mem_to_reg", 32'(bus.wb_mem_to_reg), (wb_i.op == OP_LOAD) ? 1 : 0);
    chk("wb_rd", 32'(bus.wb_rd), wb_i.rd);
    chk("stall", 32'(bus.stall), 32'(m_stall));
    chk("flush", 32'(bus.flush), 32'(m_flush));
    chk("fwd_a", 32'(bus.fwd_a), fwd_of(ex_i.rs));
    chk("fwd_b", 32'(bus.fwd_b), fwd_of(ex_i.rt));
  endtask

  task automatic advance();
    ins_t nx;
    if (cur_v == 0 || m_stall || cur_bt != 0) nx = '{0, 0, 0, 0};
    else nx = '{cur_op, cur_rs, cur_rt, cur_rd};
    wb_i = mem_i;
    mem_i = ex_i;
    ex_i = nx;
  endtask

  task automatic cyc(int v, int op, int rs, int rt, int rd, int bt);
    @(negedge clk);
    drive(v, op, rs, rt, rd, bt);
    #1 check_all();
    @(posedge clk);
    if (rst_n) advance();
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  // presents an instruction, then pulls reset mid-cycle and holds it across one edge
  task automatic reset_during(int v, int op, int rs, int rt, int rd, int bt);
    @(negedge clk);
    drive(v, op, rs, rt, rd, bt);
    #1 check_all();
    rst_n = 1'b0;
    #1 clear_model();
    check_all();
    @(posedge clk);
    #1 check_all();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int v, op, rs, rt, rd, bt;
    clear_model();
    // in reset with a jump and a taken branch presented: everything reads 0
    drive(1, OP_JUMP, 1, 2, 3, 1);
    #2 check_all();
    @(posedge clk);
    #1 check_all();
    #1 rst_n = 1'b1;
    idle(1);

    // load-use: one stall cycle, then MEM/WB forwarding
    cyc(1, OP_LOAD, 1, 0, 3, 0);
    cyc(1, OP_ADD, 3, 4, 5, 0);
    cyc(1, OP_ADD, 3, 4, 5, 0);
    idle(3);
    // back-to-back ALU dependency: EX/MEM forwarding on both operands
    cyc(1, OP_ADD, 1, 1, 2, 0);
    cyc(1, OP_ADD, 2, 2, 6, 0);
    idle(3);
    // jump: flush in ID, no register write downstream
    cyc(1, OP_JUMP, 0, 0, 7, 0);
    cyc(0, 0, 0, 0, 0, 0);
    idle(3);
    // taken branch coinciding with a load-use condition
    cyc(1, OP_LOAD, 2, 0, 3, 0);
    cyc(1, OP_BEQ, 3, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    idle(3);
    // register 0 is never a hazard or forwarding source
    cyc(1, OP_ADD, 1, 2, 0, 0);
    cyc(1, OP_ADD, 0, 0, 1, 0);
    cyc(1, OP_LOAD, 1, 1, 0, 0);
    cyc(1, OP_ADD, 0, 0, 2, 0);
    idle(3);
    // remaining decode entries and an unlisted opcode
    cyc(1, OP_STORE, 1, 2, 4, 0);
    cyc(1, OP_BGT, 1, 2, 0, 0);
    cyc(1, OP_BLE, 3, 4, 0, 0);
    cyc(1, 7, 3, 4, 5, 0);
    cyc(1, 15, 1, 1, 6, 0);
    idle(4);
    // reset mid-stall, then the same consumer sees an empty pipe
    cyc(1, OP_LOAD, 1, 0, 4, 0);
    reset_during(1, OP_ADD, 4, 4, 5, 0);
    cyc(1, OP_ADD, 4, 4, 5, 0);
    idle(3);
    // reset mid-flush
    cyc(1, OP_ADD, 1, 1, 3, 0);
    reset_during(1, OP_JUMP, 0, 0, 0, 1);
    idle(2);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        reset_during(1, OP_ADD, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 1);
        continue;
      end
      if (m_stall) begin
        v = cur_v; op = cur_op; rs = cur_rs; rt = cur_rt; rd = cur_rd;
      end else if (m_flush) begin
        v = 0; op = 0; rs = 0; rt = 0; rd = 0;
      end else begin
        v = ($urandom_range(0, 7) != 0) ? 1 : 0;
        case ($urandom_range(0, 9))
          0: op = OP_JUMP;
          1: op = OP_BEQ;
          2: op = OP_BGT;
          3: op = OP_BLE;
          4, 5: op = OP_LOAD;
          6: op = OP_STORE;
          7, 8: op = OP_ADD;
          default: op = $urandom_range(0, 15);
        endcase
        rs = $urandom_range(0, 7);
        rt = $urandom_range(0, 7);
        rd = $urandom_range(0, 7);
      end
      bt = ($urandom_range(0, 11) == 0) ? 1 : 0;
      cyc(v, op, rs, rt, rd, bt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter OPW, default 4, is the opcode width.
REQ-002 Parameter RAW, default 3, is the register-address width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset. The ports are clk and rst_n.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 id_valid  in  1  IF/ID register holds a real instruction.
REQ-007 id_opcode  in  OPW  opcode in the IF/ID register.
REQ-008 id_rs, id_rt, id_rd  in  RAW each  source and destination addresses of the ID instruction; id_rd is already selected by the datapath.
REQ-009 ex_branch_taken  in  1  branch condition resolved true in EX.
REQ-010 ex_alu_op  out  3; ex_se_op  out  1; ex_branch  out  3 ({gt,le,eq}).
REQ-011 mem_read  out  1; mem_write  out  1.
REQ-012 wb_reg_write  out  1; wb_mem_to_reg  out  2; wb_rd  out  RAW.
REQ-013 stall  out  1  hold PC and IF/ID.
REQ-014 flush  out  1  clear IF/ID.
REQ-015 fwd_a, fwd_b  out  2 each  ALU operand source: 00 register file, 01 MEM/WB, 10 EX/MEM.

Function
REQ-016 The ID stage SHALL decode id_opcode combinationally, through the package decode table, into one control word: alu_op, se_op, branch[2:0], jump, mem_read, mem_write, reg_write, mem_to_reg. Opcodes absent from the table decode to all zeros.
REQ-017 The control word, plus id_rs/id_rt/id_rd, SHALL be registered through the ID/EX, EX/MEM and MEM/WB stages. Each field is output from its consuming stage, one cycle per stage.
REQ-018 A load-use hazard SHALL raise stall combinationally in the same cycle. The hazard condition: id_valid, ID/EX mem_read=1, ID/EX rd!=0, and ID/EX rd equals id_rs or id_rt.
REQ-019 During stall the ID/EX register SHALL load a bubble (all control zero), and EX/MEM and MEM/WB SHALL advance normally.
REQ-020 A decoded jump in ID (with id_valid) SHALL raise flush for that cycle. The jump itself proceeds down the pipe with no register write.
REQ-021 When ex_branch_taken=1, the block SHALL raise flush, and ID/EX SHALL load a bubble on the next edge.
REQ-022 If a flush cause and stall coincide, flush SHALL win and stall SHALL be 0.
REQ-023 If id_valid=0, ID/EX SHALL load a bubble.
REQ-024 fwd_a (operand id_rs in EX) SHALL be 10 when EX/MEM reg_write=1, EX/MEM rd!=0 and EX/MEM rd matches. Otherwise it is 01 on the same test against MEM/WB, otherwise 00. fwd_b follows the same rule for rt. EX/MEM has priority.
REQ-025 Register 0 SHALL never be a forwarding or hazard match.
REQ-026 A stall SHALL last exactly one cycle per load-use pair, since the bubble clears the condition.

Reset
REQ-027 While rst_n=0, all stage registers SHALL clear asynchronously to zero. All registered outputs are then 0, and stall, flush, fwd_a and fwd_b read 0.
REQ-028 Reset asserted mid-stall or mid-flush SHALL discard the in-flight state. The first post-reset cycle SHALL behave as an empty pipe.

Structure
REQ-029 The shared package pipe_pkg SHALL hold the opcode constants, the control-word struct typedef, and the decode table/function. Reference opcodes: JUMP=1, BEQ=2, BGT=3, BLE=4, LOAD=5, STORE=6, ADD=8.
REQ-030 Forwarding logic SHALL be one combinational sub-module, fwd_unit, instantiated once per operand.

Verification
REQ-031 Release rst_n mid-stream: all outputs 0 while low, and the first post-reset cycle behaves as an empty pipe.
REQ-032 Issue LOAD rd=3, then ADD rs=3: stall=1 for exactly one cycle, and the bubble reaches mem_read/mem_write=0. The ADD then sees fwd_a=01.
REQ-033 Issue ADD rd=2 followed directly by ADD rs=2, rt=2: stall=0, and fwd_a=fwd_b=10 in the second ADD's EX cycle.
REQ-034 Issue JUMP: flush=1 in its ID cycle, and wb_reg_write stays 0 through WB.
REQ-035 Issue BEQ with ex_branch_taken=1 in the same cycle as a load-use condition in ID: flush=1, stall=0, and ID/EX holds a bubble next cycle.
REQ-036 Issue ADD rd=0 followed by ADD rs=0: fwd_a=00 and no stall.
